// File: rtl/if_fetch_unit_pkg.sv
// rtl/if_fetch_unit_pkg.sv - shared widths, constants and JAL offset helper for the fetch stage
package if_fetch_unit_pkg;

  localparam int          INST_ADDR_W      = 32;
  localparam int          INST_W           = 32;
  localparam logic        RST_ENABLE       = 1'b1;
  localparam logic [31:0] ZERO_WORD        = 32'h0000_0000;
  localparam logic [6:0]  OPCODE_JAL       = 7'b1101111;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // J-type immediate, sign-extended to the address width
  function automatic logic [INST_ADDR_W-1:0] jal_offset(input logic [INST_W-1:0] inst);
    return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/if_inst_fifo.sv
// rtl/if_inst_fifo.sv - small {pc, inst} queue between fetch and decode; flush beats push/pop
module if_inst_fifo
  import if_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int DW    = INST_ADDR_W + INST_W,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_flush,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [DW-1:0] i_data,
  output logic [DW-1:0] o_data,
  output logic          o_full,
  output logic [CW-1:0] o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  // Room is judged on the count before any same-cycle pop
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_count = r_count;
  assign o_data  = r_mem[r_rptr];
  assign w_push  = i_push & ~o_full & ~i_flush;
  assign w_pop   = i_pop & (r_count != '0) & ~i_flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[r_wptr] <= i_data;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - fetch PC, tag-matched return capture and redirect flush
// Optional JAL predecode redirect under IF_JAL_PREDECODE_EN.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          IBUF_DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rdy_in,
  output logic [INST_ADDR_W-1:0] fetch_pc_o,
  input  logic                   mem_pc_done_i,
  input  logic [INST_W-1:0]      mem_inst_i,
  input  logic [INST_ADDR_W-1:0] mem_pc_num_i,
  input  logic                   branch_en_i,
  input  logic [INST_ADDR_W-1:0] branch_target_i,
  input  logic                   id_ready_i,
  output logic                   id_valid_o,
  output logic [INST_ADDR_W-1:0] id_pc_o,
  output logic [INST_W-1:0]      id_inst_o
);

  localparam int CW = $clog2(IBUF_DEPTH) + 1;

  logic [INST_ADDR_W-1:0]        r_fetch_pc;
  logic [INST_ADDR_W-1:0]        w_next_pc;
  logic [INST_ADDR_W+INST_W-1:0] w_head;
  logic [CW-1:0]                 w_count;
  logic                          w_full;
  logic                          w_accept;
  logic                          w_redirect;
  logic                          w_pop;

  assign w_redirect = rdy_in & branch_en_i;
  assign w_accept   = rdy_in & mem_pc_done_i & (mem_pc_num_i == r_fetch_pc)
                    & ~w_full & ~branch_en_i;
  assign w_pop      = rdy_in & id_valid_o & id_ready_i & ~branch_en_i;

`ifdef IF_JAL_PREDECODE_EN
  assign w_next_pc = (mem_inst_i[6:0] == OPCODE_JAL) ? mem_pc_num_i + jal_offset(mem_inst_i)
                                                     : mem_pc_num_i + 32'd4;
`else
  assign w_next_pc = r_fetch_pc + 32'd4;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) begin
      r_fetch_pc <= RESET_PC;
    end else if (w_redirect) begin
      r_fetch_pc <= {branch_target_i[31:2], 2'b00};
    end else if (w_accept) begin
      r_fetch_pc <= w_next_pc;
    end
  end

  if_inst_fifo #(
    .DEPTH (IBUF_DEPTH),
    .DW    (INST_ADDR_W + INST_W),
    .CW    (CW)
  ) u_ibuf (
    .clk     (clk),
    .rst     (rst),
    .i_flush (w_redirect),
    .i_push  (w_accept),
    .i_pop   (w_pop),
    .i_data  ({mem_pc_num_i, mem_inst_i}),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_count (w_count)
  );

  assign fetch_pc_o = r_fetch_pc;
  assign id_valid_o = (w_count != '0);
  assign id_pc_o    = w_head[INST_ADDR_W+INST_W-1:INST_W];
  assign id_inst_o  = w_head[INST_W-1:0];

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the memory controller.
- Owns the architectural fetch PC and drives it onto the controller's `pc` input.
- Accepts `pc_done`/`inst_o`/`pc_num` returns and queues {pc, inst} pairs in a small buffer for the decode stage.
- Handles branch redirects by flushing the queue and discarding stale returns, matched by PC tag.

Parameters:
- RESET_PC, 32'h0000_0000, fetch PC loaded on reset.
- IBUF_DEPTH, 2, instruction-buffer entries; power of two, minimum 2.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  reset; asynchronous, active-high.
- rdy_in  in  1  global ready; low freezes all state.
- fetch_pc_o  out  32  PC to the memory controller's `pc` input.
- mem_pc_done_i  in  1  one-cycle fetch-complete strobe from the memory controller.
- mem_inst_i  in  32  fetched instruction; valid with mem_pc_done_i.
- mem_pc_num_i  in  32  PC tag of the returned instruction.
- branch_en_i  in  1  redirect request from execute, one cycle.
- branch_target_i  in  32  redirect target.
- id_ready_i  in  1  decode can accept this cycle.
- id_valid_o  out  1  buffer head is valid.
- id_pc_o  out  32  PC of buffer head.
- id_inst_o  out  32  instruction of buffer head.

Behaviour:
- Reset (async, rst=1):
  - fetch_pc <= RESET_PC.
  - Buffer empty; read/write pointers and count = 0.
  - id_valid_o=0, id_pc_o=0, id_inst_o=0.
- fetch_pc_o is a register and stays stable until a matching return is accepted or a redirect occurs. The controller may re-fetch the same PC repeatedly (cache hits); duplicates are harmless.
- Accept condition (one cycle): rdy_in & mem_pc_done_i & (mem_pc_num_i == fetch_pc) & (count < IBUF_DEPTH) & !branch_en_i.
  - On accept: push {mem_pc_num_i, mem_inst_i}; fetch_pc <= fetch_pc + 4 (32-bit wrap, 32'hFFFF_FFFC -> 0).
- A return whose tag mismatches, or that arrives while the buffer is full, is dropped silently. fetch_pc is unchanged.
- Full check uses the count before the pop: a push in the same cycle as a pop from a full buffer is refused.
- Pop: id_valid_o = (count != 0). id_pc_o/id_inst_o show the head combinationally from the buffer registers. Pop when rdy_in & id_valid_o & id_ready_i.
- Redirect (rdy_in & branch_en_i):
  - fetch_pc <= {branch_target_i[31:2], 2'b00}.
  - Buffer flushed (count=0, pointers=0).
  - Redirect overrides any push or pop in the same cycle; id_valid_o is 0 from the next cycle.
- In-flight fetch of the old PC completes in the controller. Its tag then mismatches and the return is dropped. If the target equals the in-flight PC, the return is accepted, which is correct.
- rdy_in=0: no push, pop, redirect or PC change. Outputs hold. branch_en_i is ignored; execute holds it until rdy_in=1.
- Pointer wrap: pointers are log2(IBUF_DEPTH) bits and wrap naturally. count is log2(IBUF_DEPTH)+1 bits.
- Reset mid-fetch: state clears immediately. The controller's late return is tagged with the old PC and is dropped unless it equals RESET_PC.

Optional Feature:
- Macro: IF_JAL_PREDECODE_EN.
- Defined: on accept, if mem_inst_i[6:0] == 7'b1101111 (JAL), fetch_pc <= mem_pc_num_i + sext({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}) instead of +4. Execute must not redirect for JAL in this configuration.
- Undefined: always +4; execute redirects JAL via branch_en_i.

Decomposition:
- Shared package/defines header:
  - InstAddrBus / InstBus widths (32).
  - RstEnable level.
  - ZeroWord.
  - OPCODE_JAL constant.
  - Default RESET_PC.
- One sub-module: if_inst_fifo. Parameterised depth, 64-bit {pc, inst} entries, push/pop/flush, full/empty/count. Flush has priority over push/pop.
- PC register, tag compare and predecode stay in the top module.

Test Plan:
- Reset, RESET_PC=0: return pc_num=0 inst=32'h00000013 -> fetch_pc_o=4 next cycle; id_valid_o=1, id_pc_o=0, id_inst_o=32'h00000013.
- id_ready_i=0, three matching returns at PCs 0, 4, 8 -> first two accepted, fetch_pc_o holds 8, third dropped. Raise id_ready_i -> heads 0 then 4 pop in order, then PC 8 is re-accepted.
- Buffer holding PC 0x10, 0x14; branch_en_i with target 0x103 -> fetch_pc_o=0x100, id_valid_o=0 next cycle. Stale return pc_num=0x18 -> dropped.
- Branch and matching return in the same cycle -> return not pushed, fetch_pc=target.
- rdy_in=0 with pc_done, id_ready_i and branch_en_i all active -> no state change. rdy_in=1 -> normal operation resumes.
- IF_JAL_PREDECODE_EN defined: at PC 0x20, inst 32'h0100006F (jal x0, +16) -> fetch_pc_o=0x30 next cycle. Undefined -> 0x24.
